// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the s-core hazard controller.
// Forwarding-select encodings, default register-address width, stage metadata bundle.
package pipe_hazard_ctrl_pkg;

  localparam int RA_W_DEFAULT = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic                    valid;
    logic [RA_W_DEFAULT-1:0] rd;
    logic                    we;
    logic                    ld;
  } stage_meta_t;

  typedef enum logic [2:0] {
    ACT_RESET  = 3'd0,
    ACT_FREEZE = 3'd1,
    ACT_FLUSH  = 3'd2,
    ACT_LDUSE  = 3'd3,
    ACT_HOLD   = 3'd4,
    ACT_RUN    = 3'd5
  } hz_act_e;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel_unit.sv
// Combinational forwarding compare for one EX source operand.
// The MEM producer wins over WB; loads in MEM and x0 are never forwarded.
module fwd_sel_unit
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RA_W = RA_W_DEFAULT
) (
  input  logic            i_use,
  input  logic [RA_W-1:0] i_rs,
  input  stage_meta_t     i_mem,
  input  logic            i_wb_v,
  input  logic            i_wb_we,
  input  logic [RA_W-1:0] i_wb_rd,
  output logic [1:0]      o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_use && i_mem.valid && i_mem.we && !i_mem.ld &&
        (i_mem.rd != {RA_W{1'b0}}) && (i_mem.rd == i_rs)) begin
      o_sel = FWD_MEM;
    end else if (i_use && i_wb_v && i_wb_we &&
                 (i_wb_rd != {RA_W{1'b0}}) && (i_wb_rd == i_rs)) begin
      o_sel = FWD_WB;
    end else begin
      o_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward scheduler for the 5-stage s-core, using a shadow of EX/MEM/WB metadata.
// Define PIPE_HAZARD_PERF_EN to add saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RA_W  = RA_W_DEFAULT
`ifdef PIPE_HAZARD_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_id_valid,
  input  logic [RA_W-1:0] i_id_rs1,
  input  logic [RA_W-1:0] i_id_rs2,
  input  logic            i_id_use_rs1,
  input  logic            i_id_use_rs2,
  input  logic [RA_W-1:0] i_id_rd,
  input  logic            i_id_reg_we,
  input  logic            i_id_is_load,
  input  logic            i_ex_br_taken,
  input  logic            i_mem_busy,
  input  logic            i_hold,
  output logic            o_pc_stall,
  output logic            o_if_id_stall,
  output logic            o_if_id_flush,
  output logic            o_id_ex_bubble,
  output logic            o_pipe_freeze,
  output logic [1:0]      o_fwd_rs1_sel,
  output logic [1:0]      o_fwd_rs2_sel
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  stage_meta_t     r_ex;
  logic [RA_W-1:0] r_ex_rs1;
  logic [RA_W-1:0] r_ex_rs2;
  logic            r_ex_u1;
  logic            r_ex_u2;
  stage_meta_t     r_mem;
  logic            r_wb_v;
  logic [RA_W-1:0] r_wb_rd;
  logic            r_wb_we;

  hz_act_e         w_act;
  logic            w_load_use;
  logic            w_br_flush;
  logic [1:0]      w_fwd1;
  logic [1:0]      w_fwd2;

  // Priority resolution: reset, MEM freeze, branch flush, load-use, external hold.
  always_comb begin
    w_br_flush = r_ex.valid && i_ex_br_taken;
    w_load_use = i_id_valid && r_ex.valid && r_ex.ld && r_ex.we &&
                 (r_ex.rd != {RA_W{1'b0}}) &&
                 ((i_id_use_rs1 && (i_id_rs1 == r_ex.rd)) ||
                  (i_id_use_rs2 && (i_id_rs2 == r_ex.rd)));
    w_act = ACT_RUN;
    if (i_rst) begin
      w_act = ACT_RESET;
    end else if (i_mem_busy) begin
      w_act = ACT_FREEZE;
    end else if (w_br_flush) begin
      w_act = ACT_FLUSH;
    end else if (w_load_use) begin
      w_act = ACT_LDUSE;
    end else if (i_hold) begin
      w_act = ACT_HOLD;
    end else begin
      w_act = ACT_RUN;
    end
  end

  always_comb begin
    o_pc_stall     = 1'b0;
    o_if_id_stall  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_pipe_freeze  = 1'b0;
    case (w_act)
      ACT_RESET: begin
        o_if_id_flush  = 1'b1;
        o_id_ex_bubble = 1'b1;
      end
      ACT_FREEZE: begin
        o_pc_stall    = 1'b1;
        o_if_id_stall = 1'b1;
        o_pipe_freeze = 1'b1;
      end
      ACT_FLUSH: begin
        o_if_id_flush  = 1'b1;
        o_id_ex_bubble = 1'b1;
      end
      ACT_LDUSE, ACT_HOLD: begin
        o_pc_stall     = 1'b1;
        o_if_id_stall  = 1'b1;
        o_id_ex_bubble = 1'b1;
      end
      ACT_RUN: begin
        o_pc_stall = 1'b0;
      end
      default: begin
        o_pc_stall = 1'b0;
      end
    endcase
  end

  // A freeze holds EX and MEM and drops WB; any other non-reset cycle shifts the shadow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex     <= '0;
      r_ex_rs1 <= {RA_W{1'b0}};
      r_ex_rs2 <= {RA_W{1'b0}};
      r_ex_u1  <= 1'b0;
      r_ex_u2  <= 1'b0;
      r_mem    <= '0;
      r_wb_v   <= 1'b0;
      r_wb_rd  <= {RA_W{1'b0}};
      r_wb_we  <= 1'b0;
    end else if (w_act == ACT_FREEZE) begin
      r_wb_v <= 1'b0;
    end else begin
      r_ex.valid <= (w_act == ACT_RUN) ? i_id_valid : 1'b0;
      r_ex.rd    <= i_id_rd;
      r_ex.we    <= i_id_reg_we;
      r_ex.ld    <= i_id_is_load;
      r_ex_rs1   <= i_id_rs1;
      r_ex_rs2   <= i_id_rs2;
      r_ex_u1    <= i_id_use_rs1;
      r_ex_u2    <= i_id_use_rs2;
      r_mem      <= r_ex;
      r_wb_v     <= r_mem.valid;
      r_wb_rd    <= r_mem.rd;
      r_wb_we    <= r_mem.we;
    end
  end

  fwd_sel_unit #(.RA_W(RA_W)) u_fwd_rs1 (
    .i_use   (r_ex_u1),
    .i_rs    (r_ex_rs1),
    .i_mem   (r_mem),
    .i_wb_v  (r_wb_v),
    .i_wb_we (r_wb_we),
    .i_wb_rd (r_wb_rd),
    .o_sel   (w_fwd1)
  );

  fwd_sel_unit #(.RA_W(RA_W)) u_fwd_rs2 (
    .i_use   (r_ex_u2),
    .i_rs    (r_ex_rs2),
    .i_mem   (r_mem),
    .i_wb_v  (r_wb_v),
    .i_wb_we (r_wb_we),
    .i_wb_rd (r_wb_rd),
    .o_sel   (w_fwd2)
  );

  assign o_fwd_rs1_sel = i_rst ? FWD_RF : w_fwd1;
  assign o_fwd_rs2_sel = i_rst ? FWD_RF : w_fwd2;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating event counters; a flush only counts when it actually wins priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= {CNT_W{1'b0}};
      r_flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (((w_act == ACT_FREEZE) || (w_act == ACT_LDUSE)) && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if ((w_act == ACT_FLUSH) && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed test-plan scenarios plus random traffic against
// an instruction-level pipeline model (EX/MEM/WB slots shifted per cycle).
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
  } ins_t;

  logic       clk = 1'b0;
  logic       rst_i, id_valid, use1, use2, reg_we, is_load, br_taken, mem_busy, hold_i;
  logic [4:0] rs1, rs2, rd;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pipe_freeze;
  logic [1:0] fwd1, fwd2;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
  logic [31:0] m_stall, m_flush, s_stall, s_flush;
`endif

  ins_t       pipe [3];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       s_pc, s_ifs, s_fl, s_bub, s_fz;
  logic [1:0] s_f1, s_f2;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst_i),
    .i_id_valid     (id_valid),
    .i_id_rs1       (rs1),
    .i_id_rs2       (rs2),
    .i_id_use_rs1   (use1),
    .i_id_use_rs2   (use2),
    .i_id_rd        (rd),
    .i_id_reg_we    (reg_we),
    .i_id_is_load   (is_load),
    .i_ex_br_taken  (br_taken),
    .i_mem_busy     (mem_busy),
    .i_hold         (hold_i),
    .o_pc_stall     (pc_stall),
    .o_if_id_stall  (if_id_stall),
    .o_if_id_flush  (if_id_flush),
    .o_id_ex_bubble (id_ex_bubble),
    .o_pipe_freeze  (pipe_freeze),
    .o_fwd_rs1_sel  (fwd1),
    .o_fwd_rs2_sel  (fwd2)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .o_stall_cnt    (stall_cnt),
    .o_flush_cnt    (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Newest non-load producer of src among MEM (slot 1) and WB (slot 2); x0 never matches.
  function automatic logic [1:0] fwd_of(input logic use_s, input logic [4:0] src);
    if (!use_s) return 2'b00;
    for (int s = 1; s <= 2; s++) begin
      if (pipe[s].v && pipe[s].we && pipe[s].rd != 5'd0 && pipe[s].rd == src &&
          !(s == 1 && pipe[s].ld))
        return (s == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic cyc(input logic r, input logic v, input logic [4:0] a1, input logic [4:0] a2,
                     input logic u1, input logic u2, input logic [4:0] d, input logic we,
                     input logic ld, input logic br, input logic busy, input logic hld);
    logic lu, bf;
    logic e_pc, e_ifs, e_fl, e_bub, e_fz;
    logic [1:0] e1, e2;
    ins_t nw;
    @(negedge clk);
    rst_i = r; id_valid = v; rs1 = a1; rs2 = a2; use1 = u1; use2 = u2;
    rd = d; reg_we = we; is_load = ld; br_taken = br; mem_busy = busy; hold_i = hld;
    #1;
    s_pc = pc_stall; s_ifs = if_id_stall; s_fl = if_id_flush; s_bub = id_ex_bubble;
    s_fz = pipe_freeze; s_f1 = fwd1; s_f2 = fwd2;
    bf = pipe[0].v && br;
    lu = v && pipe[0].v && pipe[0].ld && pipe[0].we && pipe[0].rd != 5'd0 &&
         ((u1 && a1 == pipe[0].rd) || (u2 && a2 == pipe[0].rd));
    e1 = r ? 2'b00 : fwd_of(pipe[0].u1, pipe[0].rs1);
    e2 = r ? 2'b00 : fwd_of(pipe[0].u2, pipe[0].rs2);
    {e_pc, e_ifs, e_fl, e_bub, e_fz} = 5'b00000;
    if (r)              {e_fl, e_bub} = 2'b11;
    else if (busy)      {e_pc, e_ifs, e_fz} = 3'b111;
    else if (bf)        {e_fl, e_bub} = 2'b11;
    else if (lu || hld) {e_pc, e_ifs, e_bub} = 3'b111;
    chk("pc_stall", {31'd0, s_pc}, {31'd0, e_pc});
    chk("if_id_stall", {31'd0, s_ifs}, {31'd0, e_ifs});
    chk("if_id_flush", {31'd0, s_fl}, {31'd0, e_fl});
    chk("id_ex_bubble", {31'd0, s_bub}, {31'd0, e_bub});
    chk("pipe_freeze", {31'd0, s_fz}, {31'd0, e_fz});
    chk("fwd_rs1_sel", {30'd0, s_f1}, {30'd0, e1});
    chk("fwd_rs2_sel", {30'd0, s_f2}, {30'd0, e2});
`ifdef PIPE_HAZARD_PERF_EN
    s_stall = stall_cnt; s_flush = flush_cnt;
    chk("stall_cnt", s_stall, m_stall);
    chk("flush_cnt", s_flush, m_flush);
`endif
    @(posedge clk);
    if (r) begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;
    end else if (busy) begin
      pipe[2].v = 1'b0;
    end else begin
      nw = '{v: v && !(bf || lu || hld), rd: d, we: we, ld: ld, rs1: a1, rs2: a2, u1: u1, u2: u2};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nw;
    end
`ifdef PIPE_HAZARD_PERF_EN
    if (r) begin
      m_stall = 32'd0; m_flush = 32'd0;
    end else if (busy || (!bf && lu)) begin
      m_stall = m_stall + 32'd1;
    end else if (bf) begin
      m_flush = m_flush + 32'd1;
    end
`endif
  endtask

  task automatic idle(input logic br, input logic busy, input logic hld);
    cyc(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, br, busy, hld);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) pipe[s] = '0;
`ifdef PIPE_HAZARD_PERF_EN
    m_stall = 32'd0; m_flush = 32'd0;
`endif
    // Reset state
    cyc(1'b1, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_flush", {31'd0, s_fl}, 32'd1);
    chk("rst_bubble", {31'd0, s_bub}, 32'd1);
    chk("rst_pc_stall", {31'd0, s_pc}, 32'd0);

    // Load-use: LW x5 then ADD reading x5
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_pc_stall", {31'd0, s_pc}, 32'd1);
    chk("lu_bubble", {31'd0, s_bub}, 32'd1);
    cyc(1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lu_one_bubble", {31'd0, s_pc}, 32'd0);
    idle(1'b0, 1'b0, 1'b0);
    chk("lu_fwd_wb", {30'd0, s_f1}, 32'd1);

    // ALU back-to-back on rs2
    cyc(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd1, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("alu_no_stall", {31'd0, s_pc}, 32'd0);
    idle(1'b0, 1'b0, 1'b0);
    chk("alu_fwd_mem", {30'd0, s_f2}, 32'd2);

    // Double producer of x7
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    chk("dbl_fwd_mem", {30'd0, s_f1}, 32'd2);

    // Load to x0 followed by a reader of x0
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("x0_no_stall", {31'd0, s_pc}, 32'd0);
    idle(1'b0, 1'b0, 1'b0);
    chk("x0_fwd", {30'd0, s_f1}, 32'd0);

    // Taken branch beats a concurrent load-use
    cyc(1'b0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("br_flush", {31'd0, s_fl}, 32'd1);
    chk("br_bubble", {31'd0, s_bub}, 32'd1);
    chk("br_pc_stall", {31'd0, s_pc}, 32'd0);
    idle(1'b1, 1'b0, 1'b0);
    chk("br_ex_cleared", {31'd0, s_fl}, 32'd0);

    // mem_busy for 3 cycles with a taken branch waiting in EX
    cyc(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b1, 1'b0);
      chk("busy_freeze", {31'd0, s_fz}, 32'd1);
      chk("busy_no_flush", {31'd0, s_fl}, 32'd0);
    end
    idle(1'b1, 1'b0, 1'b0);
    chk("busy_then_flush", {31'd0, s_fl}, 32'd1);
    idle(1'b0, 1'b0, 1'b0);
`ifdef PIPE_HAZARD_PERF_EN
    chk("perf_stall3", s_stall, 32'd3);
    chk("perf_flush1", s_flush, 32'd1);
`endif

    // External hold drains the pipeline
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 5'd2, 5'd3, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("hold_pc_stall", {31'd0, s_pc}, 32'd1);
      chk("hold_bubble", {31'd0, s_bub}, 32'd1);
    end

    // Random traffic on a small register set to provoke hazards
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 3), $urandom_range(0, 1),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          $urandom_range(0, 1), $urandom_range(0, 1),
          5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15),
          ($urandom_range(0, 99) < 10));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forward scheduler for the 5-stage pipelined s-core (IF, ID, EX, MEM, WB).
- Keeps its own registered shadow of the EX, MEM and WB stage metadata (valid, rd, write-enable, load, sources).
- From that shadow plus the ID-stage decode and the EX-stage branch result it drives:
  - PC and IF/ID hold signals
  - IF/ID flush and ID/EX bubble
  - EX-stage operand forwarding selects
- Sits beside the control unit; every pipeline register enable/clear comes from this block.

Parameters:
- RA_W, 5, register address width.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  RA_W  ID source register 1.
- id_rs2  in  RA_W  ID source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  RA_W  ID destination register.
- id_reg_we  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- ex_br_taken  in  1  EX-stage branch/jump resolved taken.
- mem_busy  in  1  data RAM not ready; MEM cannot retire.
- hold  in  1  external hold (setup mode); drain the pipeline.
- pc_stall  out  1  PC keeps its value.
- if_id_stall  out  1  IF/ID register keeps its value.
- if_id_flush  out  1  IF/ID register loads NOP/invalid.
- id_ex_bubble  out  1  ID/EX register loads NOP/invalid.
- pipe_freeze  out  1  ID/EX, EX/MEM and MEM/WB hold; WB receives a bubble.
- fwd_rs1_sel  out  2  EX operand 1 source: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- fwd_rs2_sel  out  2  EX operand 2 source, same encoding.

Behaviour:
- Shadow registers:
  - EX: ex_v, ex_rd, ex_we, ex_ld, ex_rs1, ex_rs2, ex_u1, ex_u2.
  - MEM: mem_v, mem_rd, mem_we, mem_ld.
  - WB: wb_v, wb_rd, wb_we.
  - All are cleared (0) on rst.
- While rst is high:
  - if_id_flush=1, id_ex_bubble=1, pc_stall=0, if_id_stall=0, pipe_freeze=0, fwd selects=00.
- Normal advance each cycle: ID→EX shadow (valid=id_valid), EX→MEM, MEM→WB.
- Priority 1, mem_busy=1 (freeze):
  - pc_stall=1, if_id_stall=1, pipe_freeze=1.
  - EX and MEM shadows hold; wb_v<=0.
  - Taken branch is ignored this cycle and re-evaluated next cycle, since EX is held.
- Priority 2, ex_v & ex_br_taken (branch flush):
  - if_id_flush=1, id_ex_bubble=1, pc_stall=0 so the PC loads the target.
  - Next-cycle ex_v=0.
  - Branch flush overrides load-use and hold.
- Priority 3, load-use:
  - Condition: id_valid & ex_v & ex_ld & ex_we & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: pc_stall=1, if_id_stall=1, id_ex_bubble=1; next-cycle ex_v=0.
  - Exactly one bubble is inserted per load-use pair.
- Priority 4, hold:
  - pc_stall=1, if_id_stall=1, id_ex_bubble=1.
  - The younger stages keep draining; after 3 cycles of hold, all shadow valids are 0.
- Forwarding (combinational, from shadow regs only):
  - fwd_rs1_sel=10 if ex_u1 & mem_v & mem_we & ~mem_ld & mem_rd≠0 & mem_rd==ex_rs1.
  - Else fwd_rs1_sel=01 if ex_u1 & wb_v & wb_we & wb_rd≠0 & wb_rd==ex_rs1.
  - Else fwd_rs1_sel=00.
  - fwd_rs2_sel is identical using ex_u2/ex_rs2.
  - MEM match takes precedence over WB match.
  - x0 is never forwarded.
- The hazard check uses only the current ID inputs and EX shadow; no multi-cycle memory of past stalls.
- rst asserted mid-stall: the next cycle is the reset state, and no held state survives.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, add outputs:
  - stall_cnt  out  CNT_W: cycles with load-use or mem_busy stall.
  - flush_cnt  out  CNT_W: taken-branch flushes.
- Both counters saturate at all-ones, clear on rst, and count only while rst=0.
- When undefined, the ports and logic are absent, and the remaining behaviour is unchanged.

Decomposition:
- Shared package/GLOBALS header holds:
  - the FWD_RF=2'b00, FWD_MEM=2'b10, FWD_WB=2'b01 constants
  - the RA_W default
  - a stage-metadata bundle typedef (valid, rd, we, ld).
- One natural sub-module: fwd_sel_unit, the pure combinational forwarding compare, instantiated twice (rs1, rs2).

Test Plan:
- Load-use: LW x5 in EX (ex_ld=1, ex_rd=5); ID ADD reads rs1=5 → one cycle of pc_stall=1, id_ex_bubble=1; the following cycle has no stall and fwd_rs1_sel=01.
- ALU back-to-back: ADD x3 followed by SUB reading rs2=3 → fwd_rs2_sel=10 in SUB's EX cycle, no stall.
- Double producer: x7 written in both MEM and WB; EX reads rs1=7 → fwd_rs1_sel=10.
- x0 hazard: load to x0, next instruction reads x0 → no stall, fwd=00.
- Branch: ex_br_taken=1 while load-use also present → if_id_flush=1, id_ex_bubble=1, pc_stall=0; next-cycle ex_v=0.
- mem_busy high for 3 cycles with a taken branch in EX → pipe_freeze=1 for 3 cycles, no flush; flush occurs on the cycle mem_busy drops. With PIPE_HAZARD_PERF_EN, stall_cnt=3 and flush_cnt=1.
